// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - M-stage data-memory bus; DMEM_ACCESS_COUNT_EN adds access counters
interface dmem_responder_if;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] DmmRD;
    logic        StallMem;
    logic        MisalignErr;
`ifdef DMEM_ACCESS_COUNT_EN
    logic [31:0] ReadCount;
    logic [31:0] WriteCount;

    modport master (
        output MemReadM, MemWriteM, ALUOutM, WriteDataM,
        input  DmmRD, StallMem, MisalignErr, ReadCount, WriteCount
    );
    modport slave (
        input  MemReadM, MemWriteM, ALUOutM, WriteDataM,
        output DmmRD, StallMem, MisalignErr, ReadCount, WriteCount
    );
`else
    modport master (
        output MemReadM, MemWriteM, ALUOutM, WriteDataM,
        input  DmmRD, StallMem, MisalignErr
    );
    modport slave (
        input  MemReadM, MemWriteM, ALUOutM, WriteDataM,
        output DmmRD, StallMem, MisalignErr
    );
`endif
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MIPS data memory with wait states and pipeline stall
// Optional read/write access counters are enabled by DMEM_ACCESS_COUNT_EN.
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic             req;
    logic             misaligned;
    logic [AW-1:0]    index;
    logic [29-AW:0]   unusedAddrBits;
    logic             memWe;
    logic [AW-1:0]    memAddr;
    logic [31:0]      memData;
    logic             misErr;
`ifdef DMEM_ACCESS_COUNT_EN
    logic             done;
    logic             doneWrite;
`endif

    assign req            = bus.MemReadM | bus.MemWriteM;
    assign misaligned     = |bus.ALUOutM[1:0];
    assign index          = bus.ALUOutM[AW+1:2];
    assign unusedAddrBits = bus.ALUOutM[31:AW+2];
    assign bus.MisalignErr = misErr;

    // Storage is deliberately left out of reset so contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (memWe) mem[memAddr] <= memData;
    end

    generate
        if (WAIT_CYCLES == 0) begin : gSingle
            assign bus.StallMem = 1'b0;
            assign bus.DmmRD    = misaligned ? 32'h0 : mem[index];
            assign memWe        = reset & bus.MemWriteM & ~misaligned;
            assign memAddr      = index;
            assign memData      = bus.WriteDataM;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset)                 misErr <= 1'b0;
                else if (req && misaligned) misErr <= 1'b1;
            end
`ifdef DMEM_ACCESS_COUNT_EN
            assign done      = req;
            assign doneWrite = bus.MemWriteM;
`endif
        end else begin : gWait
            typedef enum logic [1:0] {IDLE, BUSY, RESP} stateT;

            stateT         state;
            stateT         stateNext;
            logic [3:0]    counter;
            logic [AW-1:0] capAddr;
            logic [31:0]   capData;
            logic [31:0]   rdReg;
            logic          capWrite;
            logic          capMis;
            logic          commit;
            logic          stall;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) state <= IDLE;
                else        state <= stateNext;
            end

            // Stall is combinational in IDLE so M holds in the very cycle the request appears.
            always_comb begin
                stateNext = state;
                stall     = 1'b0;
                commit    = 1'b0;
                case (state)
                    IDLE: begin
                        stall = req;
                        if (req) stateNext = BUSY;
                    end
                    BUSY: begin
                        stall = 1'b1;
                        if (counter == 4'd1) begin
                            stateNext = RESP;
                            commit    = 1'b1;
                        end
                    end
                    RESP:    stateNext = IDLE;
                    default: stateNext = IDLE;
                endcase
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    counter  <= 4'd0;
                    capAddr  <= '0;
                    capData  <= 32'h0;
                    capWrite <= 1'b0;
                    capMis   <= 1'b0;
                    rdReg    <= 32'h0;
                    misErr   <= 1'b0;
                end else begin
                    if (state == IDLE && req) begin
                        counter  <= 4'(WAIT_CYCLES);
                        capAddr  <= index;
                        capData  <= bus.WriteDataM;
                        capWrite <= bus.MemWriteM;
                        capMis   <= misaligned;
                    end else if (state == BUSY) begin
                        counter <= counter - 4'd1;
                    end
                    if (commit) begin
                        rdReg <= capMis ? 32'h0 : (capWrite ? capData : mem[capAddr]);
                        if (capMis) misErr <= 1'b1;
                    end
                end
            end

            assign bus.StallMem = stall;
            assign bus.DmmRD    = rdReg;
            assign memWe        = commit & capWrite & ~capMis;
            assign memAddr      = capAddr;
            assign memData      = capData;
`ifdef DMEM_ACCESS_COUNT_EN
            assign done      = (state == RESP);
            assign doneWrite = capWrite;
`endif
        end
    endgenerate

`ifdef DMEM_ACCESS_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.ReadCount  <= 32'h0;
            bus.WriteCount <= 32'h0;
        end else if (done) begin
            if (doneWrite) bus.WriteCount <= bus.WriteCount + 32'd1;
            else           bus.ReadCount  <= bus.ReadCount + 32'd1;
        end
    end
`endif
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined MIPS core; it serves the memory-stage accesses the datapath initiates.
- Requests come in on MemWriteM, MemReadM, ALUOutM and WriteDataM. The block returns read data on DmmRD and drives StallMem into the hazard unit so that F/D/E/M hold while a multi-cycle access is in progress.
- Storage is a word-addressed register array with a configurable number of wait states.

Parameters:
DEPTH, 256, number of 32-bit words (power of two)
WAIT_CYCLES, 2, extra cycles per access (0..15); 0 = single-cycle memory

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
MemReadM  input  1  load in M stage
MemWriteM  input  1  store in M stage
ALUOutM  input  32  byte address
WriteDataM  input  32  store data
DmmRD  output  32  load data, sampled by the MW register
StallMem  output  1  hold pipeline; access not complete
MisalignErr  output  1  sticky: access with ALUOutM[1:0]!=0

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, counter=0, DmmRD=0, StallMem=0, MisalignErr=0.
  - Array contents are not cleared.
  - An access in flight is aborted and its write is not committed.
- Request definition:
  - req = MemReadM|MemWriteM.
  - Word index = ALUOutM[log2(DEPTH)+1:2]; upper bits are ignored, so addresses wrap modulo DEPTH words.
- Write priority: if MemReadM and MemWriteM are both 1, the access is treated as a write, and DmmRD returns WriteDataM in RESP.
- Misaligned access (ALUOutM[1:0]!=0):
  - MisalignErr is set at the completing edge and stays set until reset.
  - The write is suppressed.
  - Read data is 32'h0.
  - Timing is otherwise identical to an aligned access.
- WAIT_CYCLES=0 (no FSM):
  - StallMem is always 0.
  - DmmRD = mem[index] combinationally.
  - A write commits at the rising edge where MemWriteM=1.
- WAIT_CYCLES>0, FSM IDLE -> BUSY -> RESP -> IDLE:
  - IDLE:
    - StallMem = req (combinational, so M holds in the same cycle).
    - On req: capture address, data and type; counter=WAIT_CYCLES; go to BUSY.
  - BUSY:
    - StallMem=1; counter decrements each edge.
    - When counter==1, the next edge goes to RESP. At that edge a write is committed, or DmmRD is registered with mem[index].
  - RESP:
    - StallMem=0; DmmRD is held valid. The pipeline advances at this cycle's edge and MW captures DmmRD.
    - The next state is always IDLE. A request present in RESP is the same instruction being retired and is not re-serviced.
  - Total latency: a request first seen in IDLE at cycle t has DmmRD valid and StallMem=0 in cycle t+WAIT_CYCLES+1.
- Captured request: ALUOutM and WriteDataM changes during BUSY are ignored; the captured copy is used.
- DmmRD outside RESP holds its last value.
- Back-to-back accesses: a new request in the cycle after RESP (IDLE) starts immediately. The minimum access period is WAIT_CYCLES+2 cycles.

Optional Feature:
Macro: DMEM_ACCESS_COUNT_EN
- Defined:
  - Adds outputs ReadCount[31:0] and WriteCount[31:0], both reset to 0.
  - ReadCount increments once per completed read.
  - WriteCount increments once per completed write, including suppressed misaligned writes.
  - "Completed" means the RESP cycle, or an edge with req for WAIT_CYCLES=0.
  - Both counters wrap at 2^32.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- WAIT_CYCLES=2; write 0xDEADBEEF to addr 0x10, then read 0x10 -> StallMem=1 for 3 cycles per access; DmmRD=0xDEADBEEF in read RESP cycle.
- WAIT_CYCLES=0; store 0x12345678 to addr 0x4, load 0x4 next cycle -> StallMem never 1; DmmRD=0x12345678 same cycle.
- DEPTH=256; write 0xA5A5A5A5 to 0x400, read 0x0 -> returns 0xA5A5A5A5 (wrap).
- Store 0x11111111 to 0x3 -> MisalignErr=1 after completion; read 0x0 returns prior value; subsequent aligned ops unaffected; MisalignErr stays 1.
- Store 0x55 to 0x20 with reset pulsed low during BUSY -> StallMem=0, state IDLE immediately; later read 0x20 returns old contents (write not committed).
- MemReadM=MemWriteM=1 at 0x8 with data 0x77 -> treated as a write; DmmRD=0x77 in RESP; with DMEM_ACCESS_COUNT_EN, WriteCount=1 and ReadCount=0.
